// File: rtl/aes_pkg.sv
// Shared widths and FSM encoding for the iterative AES round sequencer.
package aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_ROUND_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

endpackage : aes_pkg

// File: rtl/aes_round_sequencer.sv
// Feeds one block/key through the round engine NUM_ROUNDS times, looping each
// pass's result back as the next pass's input, then offers the final state downstream.
module aes_round_sequencer
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS    = 10,
    parameter int unsigned ROUND_LATENCY = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   IN_VALID,
    output logic                   IN_READY,
    input  logic [AES_BLOCK_W-1:0] IN_DATA,
    input  logic [AES_BLOCK_W-1:0] IN_KEY,
    output logic                   OUT_VALID,
    input  logic                   OUT_READY,
    output logic [AES_BLOCK_W-1:0] OUT_DATA,
    output logic [AES_ROUND_W-1:0] RI_ROUND_KEY,
    output logic [AES_BLOCK_W-1:0] RI_IN_DATA,
    output logic [AES_BLOCK_W-1:0] RI_IN_KEY,
    input  logic [AES_BLOCK_W-1:0] RI_OUT_DATA,
    input  logic [AES_BLOCK_W-1:0] RI_OUT_KEY
);

    localparam int unsigned WAIT_W = $clog2(ROUND_LATENCY + 1);

    seq_state_t             r_state;
    logic [AES_BLOCK_W-1:0] r_data;
    logic [AES_BLOCK_W-1:0] r_key;
    logic [AES_ROUND_W-1:0] r_round;
    logic [WAIT_W-1:0]      r_wait;

    logic w_accept;
    logic w_round_done;
    logic w_last_round;

    assign w_accept     = IN_VALID & IN_READY;
    assign w_round_done = (r_wait == WAIT_W'(ROUND_LATENCY - 1));
    assign w_last_round = (r_round == AES_ROUND_W'(NUM_ROUNDS));

    // Sequencer FSM; engine results are captured only after a full latency window
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_data  <= '0;
            r_key   <= '0;
            r_round <= '0;
            r_wait  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_data  <= IN_DATA;
                        r_key   <= IN_KEY;
                        r_round <= AES_ROUND_W'(1);
                        r_wait  <= '0;
                        r_state <= RUN;
                    end
                end
                RUN: begin
                    if (w_round_done) begin
                        r_data <= RI_OUT_DATA;
                        r_key  <= RI_OUT_KEY;
                        r_wait <= '0;
                        if (w_last_round) begin
                            r_state <= DONE;
                        end else begin
                            r_round <= r_round + AES_ROUND_W'(1);
                        end
                    end else begin
                        r_wait <= r_wait + WAIT_W'(1);
                    end
                end
                DONE: begin
                    // Retire and accept in the same cycle goes straight back to RUN
                    if (OUT_READY) begin
                        if (w_accept) begin
                            r_data  <= IN_DATA;
                            r_key   <= IN_KEY;
                            r_round <= AES_ROUND_W'(1);
                            r_wait  <= '0;
                            r_state <= RUN;
                        end else begin
                            r_state <= IDLE;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign IN_READY     = (r_state == IDLE) | ((r_state == DONE) & OUT_READY);
    assign OUT_VALID    = (r_state == DONE);
    assign OUT_DATA     = (r_state == DONE) ? r_data  : '0;
    assign RI_ROUND_KEY = (r_state == RUN)  ? r_round : '0;
    assign RI_IN_DATA   = (r_state == RUN)  ? r_data  : '0;
    assign RI_IN_KEY    = (r_state == RUN)  ? r_key   : '0;

    a_round_bound: assert property (@(posedge clk) disable iff (rst)
        r_round <= AES_ROUND_W'(NUM_ROUNDS));

endmodule : aes_round_sequencer

// File: tb/tb_aes_round_sequencer.sv
// Directed bench for aes_round_sequencer with a stub round engine and a cycle-level model.
module tb_aes_round_sequencer;

    typedef struct {
        bit           busy;
        int           e;
        logic [127:0] d;
        logic [127:0] k;
    } mdl_t;

    logic clk = 1'b0;
    logic rst;

    // Default-parameter instance
    logic         in_valid, in_ready, out_valid, out_ready;
    logic [127:0] in_data, in_key, out_data;
    logic [3:0]   ri_round;
    logic [127:0] ri_in_data, ri_in_key, ri_out_data, ri_out_key;

    // NUM_ROUNDS=1, ROUND_LATENCY=1 instance
    logic         in_valid2, in_ready2, out_valid2, out_ready2;
    logic [127:0] in_data2, in_key2, out_data2;
    logic [3:0]   ri_round2;
    logic [127:0] ri_in_data2, ri_in_key2, ri_out_data2, ri_out_key2;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_on  = 1'b0;
    mdl_t m1, m2;

    always #5 clk = ~clk;

    aes_round_sequencer #(.NUM_ROUNDS(10), .ROUND_LATENCY(4)) u_dut (
        .clk(clk), .rst(rst),
        .IN_VALID(in_valid), .IN_READY(in_ready), .IN_DATA(in_data), .IN_KEY(in_key),
        .OUT_VALID(out_valid), .OUT_READY(out_ready), .OUT_DATA(out_data),
        .RI_ROUND_KEY(ri_round), .RI_IN_DATA(ri_in_data), .RI_IN_KEY(ri_in_key),
        .RI_OUT_DATA(ri_out_data), .RI_OUT_KEY(ri_out_key)
    );

    aes_round_sequencer #(.NUM_ROUNDS(1), .ROUND_LATENCY(1)) u_dut2 (
        .clk(clk), .rst(rst),
        .IN_VALID(in_valid2), .IN_READY(in_ready2), .IN_DATA(in_data2), .IN_KEY(in_key2),
        .OUT_VALID(out_valid2), .OUT_READY(out_ready2), .OUT_DATA(out_data2),
        .RI_ROUND_KEY(ri_round2), .RI_IN_DATA(ri_in_data2), .RI_IN_KEY(ri_in_key2),
        .RI_OUT_DATA(ri_out_data2), .RI_OUT_KEY(ri_out_key2)
    );

    // Stub engine, latency 4: combinational result seen 4 cycles after inputs settle
    logic [127:0] d_h [3];
    logic [127:0] k_h [3];
    logic [3:0]   r_h [3];
    always @(posedge clk) begin
        d_h[0] <= ri_in_data; d_h[1] <= d_h[0]; d_h[2] <= d_h[1];
        k_h[0] <= ri_in_key;  k_h[1] <= k_h[0]; k_h[2] <= k_h[1];
        r_h[0] <= ri_round;   r_h[1] <= r_h[0]; r_h[2] <= r_h[1];
    end
    assign ri_out_data = d_h[2] + 128'd1;
    assign ri_out_key  = k_h[2] ^ {124'd0, r_h[2]};

    // Stub engine, latency 1
    assign ri_out_data2 = ri_in_data2 + 128'd1;
    assign ri_out_key2  = ri_in_key2 ^ {124'd0, ri_round2};

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
        end
    endtask

    // Model: a block is "elapsed e cycles since accept"; running while e < n*l
    task automatic model_step(input int n, input int l, input bit r, input bit iv,
                              input bit ordy, input logic [127:0] id,
                              input logic [127:0] ik, inout mdl_t m);
        if (r) begin
            m.busy = 1'b0;
        end else if (!m.busy) begin
            if (iv) begin m.busy = 1'b1; m.e = 0; m.d = id; m.k = ik; end
        end else if (m.e < n * l) begin
            m.e++;
        end else if (ordy) begin
            if (iv) begin m.e = 0; m.d = id; m.k = ik; end
            else    m.busy = 1'b0;
        end
    endtask

    task automatic model_check(input string tag, input int n, input int l, input mdl_t m,
                               input bit ordy, input logic ir, input logic ov,
                               input logic [127:0] od, input logic [3:0] rr,
                               input logic [127:0] rd_act, input logic [127:0] rk_act);
        bit running, done;
        int rd;
        logic [127:0] kx;
        running = m.busy && (m.e < n * l);
        done    = m.busy && (m.e >= n * l);
        rd      = m.busy ? m.e / l : 0;
        kx      = m.k;
        for (int j = 1; j <= rd; j++) kx ^= 128'(j);
        chk({tag, ".in_ready"},  128'(ir), 128'(!m.busy || (done && ordy)));
        chk({tag, ".out_valid"}, 128'(ov), 128'(done));
        chk({tag, ".out_data"},  od, done ? m.d + 128'(n) : 128'd0);
        chk({tag, ".ri_round"},  128'(rr), running ? 128'(rd + 1) : 128'd0);
        chk({tag, ".ri_data"},   rd_act, running ? m.d + 128'(rd) : 128'd0);
        chk({tag, ".ri_key"},    rk_act, running ? kx : 128'd0);
    endtask

    always @(posedge clk) begin
        model_step(10, 4, rst, in_valid, out_ready, in_data, in_key, m1);
        model_step(1, 1, rst, in_valid2, out_ready2, in_data2, in_key2, m2);
        if (rst) chk_on = 1'b1;
    end

    always @(negedge clk) begin
        if (chk_on) begin
            model_check("d1", 10, 4, m1, out_ready, in_ready, out_valid, out_data,
                        ri_round, ri_in_data, ri_in_key);
            model_check("d2", 1, 1, m2, out_ready2, in_ready2, out_valid2, out_data2,
                        ri_round2, ri_in_data2, ri_in_key2);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until OUT_VALID, called just after the accept edge
    task automatic wait_valid(input string nm, input int budget, output int cycles);
        cycles = 0;
        while (!out_valid && cycles < budget) begin
            tick();
            cycles++;
        end
        chk({nm, ".valid_timeout"}, 128'(out_valid), 128'd1);
    endtask

    task automatic send(input logic [127:0] d, input logic [127:0] k);
        in_valid = 1'b1; in_data = d; in_key = k;
        tick();
        in_valid = 1'b0;
    endtask

    initial begin
        int c;
        rst = 1'b1;
        in_valid = 1'b0;  in_data = '0;  in_key = '0;  out_ready = 1'b1;
        in_valid2 = 1'b0; in_data2 = '0; in_key2 = '0; out_ready2 = 1'b1;
        repeat (3) tick();
        chk("rst.in_ready",  128'(in_ready),  128'd1);
        chk("rst.out_valid", 128'(out_valid), 128'd0);
        chk("rst.out_data",  out_data,        128'd0);
        chk("rst.ri_round",  128'(ri_round),  128'd0);
        rst = 1'b0;
        tick();

        // 1: single block
        send(128'd0, 128'd0);
        chk("t1.ri_round_first", 128'(ri_round), 128'd1);
        wait_valid("t1", 100, c);
        chk("t1.latency", 128'(c), 128'd40);
        chk("t1.data", out_data, 128'd10);
        tick();
        chk("t1.retired", 128'(out_valid), 128'd0);

        // 2: backpressure
        out_ready = 1'b0;
        send(128'd0, 128'd0);
        wait_valid("t2", 100, c);
        for (int i = 0; i < 20; i++) begin
            chk("t2.hold_data", out_data, 128'd10);
            chk("t2.hold_ready", 128'(in_ready), 128'd0);
            tick();
        end
        chk("t2.still_valid", 128'(out_valid), 128'd1);
        out_ready = 1'b1;
        #1;
        chk("t2.ready_on_retire", 128'(in_ready), 128'd1);
        tick();
        chk("t2.retired", 128'(out_valid), 128'd0);

        // 3: back-to-back with IN_VALID held high
        in_valid = 1'b1; in_data = 128'd0; in_key = 128'd0;
        tick();
        in_data = 128'd100;
        wait_valid("t3a", 100, c);
        chk("t3.lat_a", 128'(c), 128'd40);
        chk("t3.data_a", out_data, 128'd10);
        chk("t3.ready_in_done", 128'(in_ready), 128'd1);
        tick();
        in_valid = 1'b0;
        chk("t3.no_bubble_valid", 128'(out_valid), 128'd0);
        chk("t3.no_bubble_ri", ri_in_data, 128'd100);
        wait_valid("t3b", 100, c);
        chk("t3.lat_b", 128'(c), 128'd40);
        chk("t3.data_b", out_data, 128'd110);
        tick();

        // 4: reset during round 5
        send(128'd0, 128'd0);
        c = 0;
        while (ri_round != 4'd5 && c < 50) begin tick(); c++; end
        chk("t4.reach_round5", 128'(ri_round), 128'd5);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t4.out_valid", 128'(out_valid), 128'd0);
        chk("t4.in_ready", 128'(in_ready), 128'd1);
        chk("t4.ri_round", 128'(ri_round), 128'd0);
        send(128'd7, 128'd0);
        wait_valid("t4", 100, c);
        chk("t4.latency", 128'(c), 128'd40);
        chk("t4.data", out_data, 128'd17);
        tick();

        // 5: IN_VALID pulsed during RUN is ignored
        send(128'd0, 128'd5);
        repeat (5) tick();
        in_valid = 1'b1; in_data = 128'd55;
        for (int i = 0; i < 3; i++) begin
            chk("t5.no_ready", 128'(in_ready), 128'd0);
            tick();
        end
        in_valid = 1'b0;
        chk("t5.ri_round", 128'(ri_round), 128'd3);
        chk("t5.ri_data", ri_in_data, 128'd2);
        wait_valid("t5", 100, c);
        chk("t5.data", out_data, 128'd10);
        tick();

        // 6: NUM_ROUNDS=1, ROUND_LATENCY=1
        in_valid2 = 1'b1; in_data2 = 128'd5;
        tick();
        in_valid2 = 1'b0;
        chk("t6.run_valid", 128'(out_valid2), 128'd0);
        chk("t6.ri_data", ri_in_data2, 128'd5);
        chk("t6.ri_round", 128'(ri_round2), 128'd1);
        tick();
        chk("t6.valid", 128'(out_valid2), 128'd1);
        chk("t6.data", out_data2, 128'd6);
        tick();
        chk("t6.retired", 128'(out_valid2), 128'd0);

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog t=%0t act=running exp=finished", $time);
        $fatal(1, "watchdog");
    end

endmodule : tb_aes_round_sequencer
